// File: rtl/em_slot_arbiter_pkg.sv
// Shared types and constants for the Execute->Memory slot arbiter.
// Holds the pipeline payload layout and the requester index numbering.
// No logic lives here.
package em_slot_arbiter_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ROB_ID_W  = 7;
  localparam int CNT_W     = 16;

  // Requester numbering: bit 0 is the ALU pipe, bit 1 the multiplier pipe
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MUL = 1'b1;

  typedef struct packed {
    logic [1:0]           itype;
    logic [WORD_SIZE-1:0] pc;
    logic [2:0]           funct3;
    logic [WORD_SIZE-1:0] result;
    logic [WORD_SIZE-1:0] s2;
    logic [ROB_ID_W-1:0]  rob_id;
  } em_payload_t;

endpackage

// File: rtl/em_slot_arbiter_if.sv
// Bundle of the two requester channels and the E_M_Stage facing payload.
// Purely structural; latency and backpressure are set by whoever drives it.
// slave = arbiter view, master = requester/E_M view.
interface em_slot_arbiter_if #(
  parameter int WORD_SIZE = 32,
  parameter int ROB_ID_W  = 7
);
  // requester side, index 0 = ALU, index 1 = MUL
  logic [1:0]                     req_valid;
  logic [1:0]                     req_ready;
  logic [1:0][1:0]                req_type;
  logic [1:0][WORD_SIZE-1:0]      req_pc;
  logic [1:0][2:0]                req_funct3;
  logic [1:0][WORD_SIZE-1:0]      req_result;
  logic [1:0][WORD_SIZE-1:0]      req_s2;
  logic [1:0][ROB_ID_W-1:0]       req_rob_id;

  // E_M_Stage side
  logic [1:0]                     instruction_type;
  logic [WORD_SIZE-1:0]           pc;
  logic [2:0]                     funct3;
  logic [WORD_SIZE-1:0]           aluResult;
  logic [WORD_SIZE-1:0]           s2;
  logic [ROB_ID_W-1:0]            rob_id;
  logic                           valid;
  logic                           stall;

  modport slave (
    input  req_valid, req_type, req_pc, req_funct3, req_result, req_s2, req_rob_id,
    output req_ready, instruction_type, pc, funct3, aluResult, s2, rob_id, valid, stall
  );

  modport master (
    output req_valid, req_type, req_pc, req_funct3, req_result, req_s2, req_rob_id,
    input  req_ready, instruction_type, pc, funct3, aluResult, s2, rob_id, valid, stall
  );
endinterface

// File: rtl/em_slot_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a registered last-grant pointer.
// Zero-latency combinational grant; pointer updates on the edge after a grant.
// block forces no grant and freezes the pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  // grant the lone requester, or on a tie the one that did not win last
  always_comb begin
    gnt = 2'b00;
    if (!block) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // remember the winner; hold the pointer on idle, stalled or flushed cycles
  always_comb begin
    last_grant_d = last_grant_q;
    if (|gnt) last_grant_d = gnt[1];
  end

  // pointer resets to 1 so the ALU wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/em_slot_arbiter.sv
// Shares the single E->M pipeline slot between the ALU and MUL pipes.
// Zero-latency combinational grant and payload mux; only pointer/counter are registered.
// mem_stall or flush withholds every grant; requesters hold until they see req_ready.
module em_slot_arbiter
  import em_slot_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = em_slot_arbiter_pkg::WORD_SIZE,
  parameter int ROB_ID_W  = em_slot_arbiter_pkg::ROB_ID_W,
  parameter int CNT_W     = em_slot_arbiter_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_stall,
  input  logic             flush,
  em_slot_arbiter_if.slave bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef struct packed {
    logic [1:0]           itype;
    logic [WORD_SIZE-1:0] pc;
    logic [2:0]           funct3;
    logic [WORD_SIZE-1:0] result;
    logic [WORD_SIZE-1:0] s2;
    logic [ROB_ID_W-1:0]  rob_id;
  } pld_t;

  logic [1:0]       gnt;
  logic             block;
  logic             sel;
  pld_t             pld_sel;
  logic [CNT_W-1:0] conflict_cnt_q;
  logic [CNT_W-1:0] conflict_cnt_d;

  // reset is folded in so no grant leaks out while it is asserted
  assign block = mem_stall | flush | reset;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req_valid),
    .block (block),
    .gnt   (gnt)
  );

  // payload mux: MUL only when it holds the grant, otherwise ALU (qualified by valid)
  always_comb begin
    sel            = gnt[1] ? REQ_MUL : REQ_ALU;
    pld_sel.itype  = bus.req_type[sel];
    pld_sel.pc     = bus.req_pc[sel];
    pld_sel.funct3 = bus.req_funct3[sel];
    pld_sel.result = bus.req_result[sel];
    pld_sel.s2     = bus.req_s2[sel];
    pld_sel.rob_id = bus.req_rob_id[sel];
  end

  assign bus.req_ready        = gnt;
  assign bus.valid            = |gnt;
  assign bus.stall            = mem_stall;
  assign bus.instruction_type = pld_sel.itype;
  assign bus.pc               = pld_sel.pc;
  assign bus.funct3           = pld_sel.funct3;
  assign bus.aluResult        = pld_sel.result;
  assign bus.s2               = pld_sel.s2;
  assign bus.rob_id           = pld_sel.rob_id;

  // count cycles where both pipes asked and one had to wait; saturate at all-ones
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((&bus.req_valid) && !mem_stall && !flush && (conflict_cnt_q != {CNT_W{1'b1}}))
      conflict_cnt_d = conflict_cnt_q + 1'b1;
  end

  // counter clears asynchronously so it reads zero as soon as reset rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule
